// File: rtl/operand_issue_pkg.sv
// Shared definitions for operand_issue: opcodes, FSM states and instruction field positions.
package operand_issue_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_LDI = 2'b11;

    localparam int OP_HI  = 7;
    localparam int OP_LO  = 6;
    localparam int DST_HI = 5;
    localparam int DST_LO = 4;
    localparam int S1_HI  = 3;
    localparam int S1_LO  = 2;
    localparam int S2_HI  = 1;
    localparam int S2_LO  = 0;
    localparam int IMM_HI = 3;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_WB = 2'd2,
        LDI_WR  = 2'd3
    } state_t;

endpackage

// File: rtl/operand_issue_regfile.sv
// 4x4-bit register file: two async read ports, one sync write port.
// Latency: reads combinational, write visible the cycle after we.
// Backpressure: none; a write is accepted every cycle we is high.
module opd_regfile #(
    parameter logic [3:0] RESET_VAL = 4'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  raddr1,
    input  logic [1:0]  raddr2,
    output logic [3:0]  rdata1,
    output logic [3:0]  rdata2,
    input  logic        we,
    input  logic [1:0]  waddr,
`ifdef OPERAND_ISSUE_DBG_EN
    output logic [15:0] regs_flat,
`endif
    input  logic [3:0]  wdata
);

    logic [3:0] mem [4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) mem[i] <= RESET_VAL;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

`ifdef OPERAND_ISSUE_DBG_EN
    assign regs_flat = {mem[3], mem[2], mem[1], mem[0]};
`endif

endmodule

// File: rtl/operand_issue.sv
// Decode/issue stage: reads operands, enables one execute unit, waits for write-back. Optional OPERAND_ISSUE_DBG_EN adds dbg_regs.
// Latency: enable one cycle after handshake; ALU op >= 3 cycles, LDI 2 cycles.
// Backpressure: instr_ready only in IDLE; missing write-back aborts after WB_TIMEOUT cycles with sticky err.
module operand_issue
    import operand_issue_pkg::*;
#(
    parameter int         WB_TIMEOUT    = 15,
    parameter logic [3:0] REG_RESET_VAL = 4'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [3:0]  rd1,
    output logic [3:0]  rd2,
    output logic        en_and,
    output logic        en_or,
    output logic        en_add,
    input  logic        wb_valid,
    input  logic [3:0]  wb_data,
    output logic        busy,
`ifdef OPERAND_ISSUE_DBG_EN
    output logic [15:0] dbg_regs,
`endif
    output logic        err
);

    state_t     state, state_nxt;
    logic [1:0] op_q, dest_q;
    logic [3:0] imm_q;
    logic [7:0] cnt;
    logic [3:0] rdata1, rdata2;
    logic       we;
    logic [3:0] wdata;
    logic       hs;
    logic       timeout;

    assign hs      = instr_valid && (state == IDLE);
    // cnt holds completed WAIT_WB cycles, so the last allowed cycle sees WB_TIMEOUT-1
    assign timeout = (cnt == 8'(WB_TIMEOUT - 1));
    assign busy    = (state != IDLE);

    opd_regfile #(.RESET_VAL(REG_RESET_VAL)) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (instr[S1_HI:S1_LO]),
        .raddr2 (instr[S2_HI:S2_LO]),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .we     (we),
        .waddr  (dest_q),
`ifdef OPERAND_ISSUE_DBG_EN
        .regs_flat (dbg_regs),
`endif
        .wdata  (wdata)
    );

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        en_and      = 1'b0;
        en_or       = 1'b0;
        en_add      = 1'b0;
        we          = 1'b0;
        wdata       = wb_data;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid)
                    state_nxt = (instr[OP_HI:OP_LO] == OP_LDI) ? LDI_WR : ISSUE;
            end
            ISSUE: begin
                case (op_q)
                    OP_AND:  en_and = 1'b1;
                    OP_OR:   en_or  = 1'b1;
                    OP_ADD:  en_add = 1'b1;
                    default: ;
                endcase
                state_nxt = WAIT_WB;
            end
            WAIT_WB: begin
                // a write-back arriving on the timeout cycle still wins
                if (wb_valid) begin
                    we        = 1'b1;
                    state_nxt = IDLE;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            LDI_WR: begin
                we        = 1'b1;
                wdata     = imm_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= 2'b00;
            dest_q <= 2'b00;
            imm_q  <= 4'h0;
            rd1    <= 4'h0;
            rd2    <= 4'h0;
            cnt    <= 8'd0;
            err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                op_q   <= instr[OP_HI:OP_LO];
                dest_q <= instr[DST_HI:DST_LO];
                imm_q  <= instr[IMM_HI:IMM_LO];
                rd1    <= rdata1;
                rd2    <= rdata2;
            end
            if (state == ISSUE)
                cnt <= 8'd0;
            else if (state == WAIT_WB)
                cnt <= cnt + 8'd1;
            if (state == WAIT_WB && !wb_valid && timeout)
                err <= 1'b1;
        end
    end

endmodule
